// File: rtl/dist_pkg.sv
// Shared definitions for the distortion crossfade engine.
// Holds the shaper mode codes, FSM state encoding and default clip level.
// Imported by dist_shaper and distortion_xfade_engine.
package dist_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_HARD   = 2'd1;
  localparam logic [1:0] MODE_SOFT   = 2'd2;
  localparam logic [1:0] MODE_FUZZ   = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_XFADE = 1'b1
  } state_t;

  localparam int DEFAULT_CLIP_LVL = 8192;

endpackage

// File: rtl/dist_shaper.sv
// Single-channel waveshaper: bypass, hard clip, soft knee or fuzz.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: mode (curve select), x (signed sample in), y (shaped sample out).
module dist_shaper
  import dist_pkg::*;
#(
  parameter int W        = 16,
  parameter int CLIP_LVL = DEFAULT_CLIP_LVL
) (
  input  logic [1:0]          mode,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  localparam logic signed [W:0] CLIP_P = (W+1)'(CLIP_LVL);
  localparam logic signed [W:0] CLIP_N = -CLIP_P;

  // One extra bit so that |most-negative| is representable.
  logic signed [W:0] xe;
  logic signed [W:0] ax;
  logic signed [W:0] soft_mag;
  logic              neg;

  assign xe       = {x[W-1], x};
  assign neg      = x[W-1];
  assign ax       = neg ? -xe : xe;
  // Only used when ax > CLIP_P, so the difference is positive.
  assign soft_mag = CLIP_P + ((ax - CLIP_P) >>> 2);

  always_comb begin
    y = x;
    case (mode)
      MODE_BYPASS: y = x;
      MODE_HARD: begin
        if (xe > CLIP_P)      y = W'(CLIP_P);
        else if (xe < CLIP_N) y = W'(CLIP_N);
      end
      MODE_SOFT: begin
        if (ax > CLIP_P) y = neg ? W'(-soft_mag) : W'(soft_mag);
      end
      MODE_FUZZ: begin
        if (x == '0) y = '0;
        else         y = neg ? W'(CLIP_N) : W'(CLIP_P);
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/distortion_xfade_engine.sv
// N-channel distortion with debounced mode switch and click-free crossfade.
// Latency: out_valid exactly one clk after in_valid. Backpressure: none, accepts in_valid every cycle.
// Ports: clk, reset (async high), mode_async (raw switch), in_valid/in_data -> out_valid/out_data,
//        mode_active (mode fully applied), xfade_busy (ramp in progress).
// Build option: DIST_XFADE_EN enables the crossfade; without it mode changes apply at once.
module distortion_xfade_engine
  import dist_pkg::*;
#(
  parameter int W            = 16,
  parameter int NCH          = 2,
  parameter int RAMP_LOG2    = 6,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CLIP_LVL     = DEFAULT_CLIP_LVL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_async,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_valid,
  output logic [NCH*W-1:0] out_data,
  output logic [1:0]       mode_active,
  output logic             xfade_busy
);

  localparam int             CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  // Synchroniser and debounce.
  logic [1:0]    sync1, mode_s, cand, mode_deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      mode_s   <= '0;
      cand     <= '0;
      cnt      <= '0;
      mode_deb <= '0;
    end else begin
      sync1  <= mode_async;
      mode_s <= sync1;
      if (mode_s != cand) begin
        cand <= mode_s;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == CNT_MAX) mode_deb <= cand;
    end
  end

  // Shapers for the currently applied mode.
  logic [NCH*W-1:0] shp_old;

  for (genvar c = 0; c < NCH; c++) begin : g_old
    dist_shaper #(.W(W), .CLIP_LVL(CLIP_LVL)) u_old (
      .mode (mode_active),
      .x    (in_data[c*W +: W]),
      .y    (shp_old[c*W +: W])
    );
  end

`ifdef DIST_XFADE_EN
  localparam int PW = W + RAMP_LOG2 + 1;

  state_t                 state;
  logic [1:0]             mode_next;
  logic [RAMP_LOG2-1:0]   k;
  logic [RAMP_LOG2:0]     w_new, w_old;
  logic [NCH*W-1:0]       shp_new, mix;

  assign w_new = {1'b0, k};
  assign w_old = (RAMP_LOG2+1)'(1 << RAMP_LOG2) - w_new;

  for (genvar c = 0; c < NCH; c++) begin : g_new
    logic signed [PW-1:0] o_x, n_x, wo_x, wn_x, acc;

    dist_shaper #(.W(W), .CLIP_LVL(CLIP_LVL)) u_new (
      .mode (mode_next),
      .x    (in_data[c*W +: W]),
      .y    (shp_new[c*W +: W])
    );

    assign o_x  = PW'($signed(shp_old[c*W +: W]));
    assign n_x  = PW'($signed(shp_new[c*W +: W]));
    assign wo_x = PW'(w_old);
    assign wn_x = PW'(w_new);
    // Convex mix: the result always fits back into W bits; >>> floors.
    assign acc  = o_x * wo_x + n_x * wn_x;
    assign mix[c*W +: W] = W'(acc >>> RAMP_LOG2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode_next   <= '0;
      k           <= '0;
      mode_active <= '0;
      xfade_busy  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      out_valid <= in_valid;
      case (state)
        ST_IDLE: begin
          // A sample arriving in the ramp-start cycle still uses the old mode.
          if (in_valid) out_data <= shp_old;
          if (mode_deb != mode_active) begin
            mode_next  <= mode_deb;
            k          <= '0;
            xfade_busy <= 1'b1;
            state      <= ST_XFADE;
          end
        end
        ST_XFADE: begin
          // Ramp advances per sample; mode_deb is ignored until it completes.
          if (in_valid) begin
            out_data <= mix;
            k        <= k + 1'b1;
            if (&k) begin
              mode_active <= mode_next;
              xfade_busy  <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign xfade_busy = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_active <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= shp_old;
      if (mode_deb != mode_active) mode_active <= mode_deb;
    end
  end
`endif

endmodule
